// File: rtl/l1d_response_ctrl.sv
// L1 dcache response control: accepts decoded L2 responses, snoops the tag stage,
// resolves the hit way one cycle later and drives tag-memory and data-array writes.
module l1d_response_ctrl #(
  parameter  int L1D_WAYS         = 4,
  parameter  int L1D_SETS         = 64,
  parameter  int CACHE_LINE_BYTES = 64,
  localparam int SET_W  = $clog2(L1D_SETS),
  localparam int WAY_W  = (L1D_WAYS > 1) ? $clog2(L1D_WAYS) : 1,
  localparam int TAG_W  = 32 - $clog2(L1D_SETS) - $clog2(CACHE_LINE_BYTES),
  localparam int LADR_W = TAG_W + SET_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             resp_valid,
  output logic                             resp_ready,
  input  logic [1:0]                       resp_op,
  input  logic [LADR_W-1:0]                resp_line_adr,
  output logic                             l2i_snoop_en,
  output logic [SET_W-1:0]                 l2i_snoop_set,
  output logic                             l2i_dcache_lru_fill_en,
  output logic [SET_W-1:0]                 l2i_dcache_lru_fill_set,
  input  logic [L1D_WAYS-1:0]              dt_snoop_valid,
  input  logic [L1D_WAYS-1:0][TAG_W-1:0]   dt_snoop_tag,
  input  logic [WAY_W-1:0]                 dt_fill_lru,
  output logic [L1D_WAYS-1:0]              l2i_dtag_update_en_oh,
  output logic [SET_W-1:0]                 l2i_dtag_update_set,
  output logic [TAG_W-1:0]                 l2i_dtag_update_tag,
  output logic                             l2i_dtag_update_valid,
  output logic                             l2i_ddata_update_en,
  output logic [WAY_W-1:0]                 l2i_ddata_update_way,
  output logic [SET_W-1:0]                 l2i_ddata_update_set,
  output logic                             resp_done
);

  typedef enum logic [1:0] {
    OP_FILL   = 2'd0,
    OP_UPDATE = 2'd1,
    OP_INVAL  = 2'd2,
    OP_RSVD   = 2'd3
  } resp_op_e;

  logic              s1_valid;
  resp_op_e          s1_op;
  logic [LADR_W-1:0] s1_adr;

  logic [SET_W-1:0]    resp_set;
  logic [SET_W-1:0]    s1_set;
  logic [TAG_W-1:0]    s1_tag;
  logic                fill_hazard;
  logic                accept;
  logic                retire;
  logic [L1D_WAYS-1:0] hit_oh;
  logic                hit_any;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    fill_way;

  assign resp_set = resp_line_adr[SET_W-1:0];
  assign s1_set   = s1_adr[SET_W-1:0];
  assign s1_tag   = s1_adr[LADR_W-1:SET_W];

  // A second FILL to the set being filled must wait one cycle so its victim
  // read sees the LRU update from the first fill.
  assign fill_hazard = s1_valid && (s1_op == OP_FILL) &&
                       (resp_op == OP_FILL) && (resp_set == s1_set);

  assign resp_ready = !reset && !(resp_valid && fill_hazard);
  assign accept     = resp_valid && resp_ready;

  // Stage 0: snoop and victim requests go out in the accept cycle.
  assign l2i_snoop_en            = accept;
  assign l2i_snoop_set           = resp_set;
  assign l2i_dcache_lru_fill_en  = accept && (resp_op == OP_FILL);
  assign l2i_dcache_lru_fill_set = resp_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
    end
  end

  // NOTE: the payload registers carry no reset; they are only observed when
  // s1_valid is set, so resetting them would add logic without changing behaviour.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op  <= resp_op_e'(resp_op);
      s1_adr <= resp_line_adr;
    end
  end

  // A stage-1 entry caught by reset is dropped without any write.
  assign retire = s1_valid && !reset;

  always_comb begin
    hit_oh = '0;
    for (int w = 0; w < L1D_WAYS; w++) begin
      hit_oh[w] = dt_snoop_valid[w] && (dt_snoop_tag[w] == s1_tag);
    end
  end

  // hit_oh is at most one-hot, so OR-ing way indices yields the encoded way.
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < L1D_WAYS; w++) begin
      if (hit_oh[w]) hit_way = hit_way | WAY_W'(w);
    end
  end

  assign hit_any  = |hit_oh;
  assign fill_way = hit_any ? hit_way : dt_fill_lru;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    l2i_dtag_update_en_oh = '0;
    l2i_dtag_update_set   = s1_set;
    l2i_dtag_update_tag   = s1_tag;
    l2i_dtag_update_valid = 1'b0;
    l2i_ddata_update_en   = 1'b0;
    l2i_ddata_update_way  = hit_way;
    l2i_ddata_update_set  = s1_set;
    if (retire) begin
      unique case (s1_op)
        OP_FILL: begin
          l2i_dtag_update_en_oh = L1D_WAYS'(1) << fill_way;
          l2i_dtag_update_valid = 1'b1;
          l2i_ddata_update_en   = 1'b1;
          l2i_ddata_update_way  = fill_way;
        end
        OP_UPDATE: begin
          l2i_ddata_update_en = hit_any;
        end
        OP_INVAL: begin
          l2i_dtag_update_en_oh = hit_oh;
        end
        default: begin
        end
      endcase
    end
  end

  assign resp_done = retire;

endmodule

// File: tb/tb_l1d_response_ctrl.sv
// Randomized scoreboard bench for l1d_response_ctrl; the bench also plays the
// dcache tag stage (tags, valids, round-robin victim pointer per set).
module tb_l1d_response_ctrl;

  localparam int WAYS   = 4;
  localparam int SETS   = 64;
  localparam int LINE   = 64;
  localparam int SET_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int TAG_W  = 32 - SET_W - $clog2(LINE);
  localparam int LADR_W = TAG_W + SET_W;

  localparam logic [1:0] OP_FILL   = 2'd0;
  localparam logic [1:0] OP_UPDATE = 2'd1;
  localparam logic [1:0] OP_INVAL  = 2'd2;

  logic                        clk;
  logic                        reset;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [1:0]                  resp_op;
  logic [LADR_W-1:0]           resp_line_adr;
  logic                        l2i_snoop_en;
  logic [SET_W-1:0]            l2i_snoop_set;
  logic                        l2i_dcache_lru_fill_en;
  logic [SET_W-1:0]            l2i_dcache_lru_fill_set;
  logic [WAYS-1:0]             dt_snoop_valid;
  logic [WAYS-1:0][TAG_W-1:0]  dt_snoop_tag;
  logic [WAY_W-1:0]            dt_fill_lru;
  logic [WAYS-1:0]             l2i_dtag_update_en_oh;
  logic [SET_W-1:0]            l2i_dtag_update_set;
  logic [TAG_W-1:0]            l2i_dtag_update_tag;
  logic                        l2i_dtag_update_valid;
  logic                        l2i_ddata_update_en;
  logic [WAY_W-1:0]            l2i_ddata_update_way;
  logic [SET_W-1:0]            l2i_ddata_update_set;
  logic                        resp_done;

  l1d_response_ctrl #(
    .L1D_WAYS(WAYS), .L1D_SETS(SETS), .CACHE_LINE_BYTES(LINE)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .resp_valid              (resp_valid),
    .resp_ready              (resp_ready),
    .resp_op                 (resp_op),
    .resp_line_adr           (resp_line_adr),
    .l2i_snoop_en            (l2i_snoop_en),
    .l2i_snoop_set           (l2i_snoop_set),
    .l2i_dcache_lru_fill_en  (l2i_dcache_lru_fill_en),
    .l2i_dcache_lru_fill_set (l2i_dcache_lru_fill_set),
    .dt_snoop_valid          (dt_snoop_valid),
    .dt_snoop_tag            (dt_snoop_tag),
    .dt_fill_lru             (dt_fill_lru),
    .l2i_dtag_update_en_oh   (l2i_dtag_update_en_oh),
    .l2i_dtag_update_set     (l2i_dtag_update_set),
    .l2i_dtag_update_tag     (l2i_dtag_update_tag),
    .l2i_dtag_update_valid   (l2i_dtag_update_valid),
    .l2i_ddata_update_en     (l2i_ddata_update_en),
    .l2i_ddata_update_way    (l2i_ddata_update_way),
    .l2i_ddata_update_set    (l2i_ddata_update_set),
    .resp_done               (resp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- tag stage emulation (driven by the DUT's own writes) -----
  logic [TAG_W-1:0] ts_tag [SETS][WAYS];
  logic             ts_val [SETS][WAYS];
  int unsigned      ts_ptr [SETS];
  logic [SET_W-1:0] snoop_set_q;
  logic [WAY_W-1:0] lru_q;

  // Victim is read from pre-write state; snoop reads see same-edge writes.
  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        ts_ptr[s] <= (s + 1) % WAYS;
        for (int w = 0; w < WAYS; w++) begin
          ts_val[s][w] <= 1'b0;
          ts_tag[s][w] <= '0;
        end
      end
      snoop_set_q <= '0;
      lru_q       <= '0;
    end else begin
      if (l2i_dcache_lru_fill_en) lru_q <= WAY_W'(ts_ptr[l2i_dcache_lru_fill_set]);
      for (int w = 0; w < WAYS; w++) begin
        if (l2i_dtag_update_en_oh[w]) begin
          ts_val[l2i_dtag_update_set][w] <= l2i_dtag_update_valid;
          ts_tag[l2i_dtag_update_set][w] <= l2i_dtag_update_tag;
          if (l2i_dtag_update_valid) ts_ptr[l2i_dtag_update_set] <= (w + 1) % WAYS;
        end
      end
      if (l2i_snoop_en) snoop_set_q <= l2i_snoop_set;
    end
  end

  always_comb begin
    dt_snoop_valid = '0;
    dt_snoop_tag   = '0;
    for (int w = 0; w < WAYS; w++) begin
      dt_snoop_valid[w] = ts_val[snoop_set_q][w];
      dt_snoop_tag[w]   = ts_tag[snoop_set_q][w];
    end
  end
  assign dt_fill_lru = lru_q;

  // ---------------- reference cache model, updated in acceptance order -------
  typedef struct {
    int unsigned       cyc;
    logic [WAYS-1:0]   en_oh;
    logic [SET_W-1:0]  set;
    logic [TAG_W-1:0]  tag;
    logic              valid;
    logic              dd_en;
    logic [WAY_W-1:0]  way;
  } exp_t;

  exp_t             exp_q[$];
  logic [TAG_W-1:0] rt    [SETS][WAYS];
  bit               rv    [SETS][WAYS];
  int               rptr  [SETS];

  task automatic ref_reset();
    for (int s = 0; s < SETS; s++) begin
      rptr[s] = (s + 1) % WAYS;
      for (int w = 0; w < WAYS; w++) begin
        rv[s][w] = 1'b0;
        rt[s][w] = '0;
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [TAG_W-1:0] tag, input logic [SET_W-1:0] set);
    exp_t e;
    int   hit = -1;
    int   way;
    e.cyc = cyc; e.en_oh = '0; e.set = set; e.tag = tag;
    e.valid = 1'b0; e.dd_en = 1'b0; e.way = '0;
    for (int w = 0; w < WAYS; w++) if (rv[set][w] && rt[set][w] == tag) hit = w;
    case (op)
      OP_FILL: begin
        way     = (hit >= 0) ? hit : rptr[set];
        e.en_oh = WAYS'(1) << way;
        e.valid = 1'b1;
        e.dd_en = 1'b1;
        e.way   = WAY_W'(way);
        rv[set][way] = 1'b1;
        rt[set][way] = tag;
        rptr[set]    = (way + 1) % WAYS;
      end
      OP_UPDATE: if (hit >= 0) begin
        e.dd_en = 1'b1;
        e.way   = WAY_W'(hit);
      end
      OP_INVAL: if (hit >= 0) begin
        e.en_oh = WAYS'(1) << hit;
        rv[set][hit] = 1'b0;
      end
      default: ;
    endcase
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ---------------------------------------------------
  always @(negedge clk) begin
    exp_t            e;
    logic [WAYS-1:0] hits;
    if (reset) begin
      check("reset_ready",   32'(resp_ready), 0);
      check("reset_done",    32'(resp_done), 0);
      check("reset_tag_wr",  32'(l2i_dtag_update_en_oh), 0);
      check("reset_data_wr", 32'(l2i_ddata_update_en), 0);
      exp_q.delete();
    end else if (resp_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(resp_done), 0);
      end else begin
        e = exp_q.pop_front();
        hits = '0;
        for (int w = 0; w < WAYS; w++) hits[w] = dt_snoop_valid[w] && dt_snoop_tag[w] == e.tag;
        assert ($onehot0(hits)) else $error("FAIL snoop_hit_onehot0: hits 0x%0h", hits);
        check("done_latency", 32'(cyc), 32'(e.cyc + 1));
        check("tag_wr_oh", 32'(l2i_dtag_update_en_oh), 32'(e.en_oh));
        if (e.en_oh != '0) begin
          check("tag_wr_set",   32'(l2i_dtag_update_set), 32'(e.set));
          check("tag_wr_tag",   32'(l2i_dtag_update_tag), 32'(e.tag));
          check("tag_wr_valid", 32'(l2i_dtag_update_valid), 32'(e.valid));
        end
        check("data_wr_en", 32'(l2i_ddata_update_en), 32'(e.dd_en));
        if (e.dd_en) begin
          check("data_wr_way", 32'(l2i_ddata_update_way), 32'(e.way));
          check("data_wr_set", 32'(l2i_ddata_update_set), 32'(e.set));
        end
      end
    end else begin
      check("idle_tag_wr",  32'(l2i_dtag_update_en_oh), 0);
      check("idle_data_wr", 32'(l2i_ddata_update_en), 0);
    end
  end

  // ---------------- driver ----------------------------------------------------
  logic [1:0]       last_op  = 2'd3;
  logic [SET_W-1:0] last_set = '0;
  int               last_cyc = -10;

  // Called and returns at posedge+1; leaves resp_valid low.
  task automatic send(input logic [1:0] op, input logic [TAG_W-1:0] tag, input logic [SET_W-1:0] set);
    int stalls = 0;
    int exp_stall;
    bit done = 1'b0;
    resp_valid    = 1'b1;
    resp_op       = op;
    resp_line_adr = {tag, set};
    @(negedge clk);
    exp_stall = (op == OP_FILL && last_op == OP_FILL && last_set == set && last_cyc + 1 == cyc) ? 1 : 0;
    while (!done) begin
      if (resp_ready) begin
        check("snoop_en",    32'(l2i_snoop_en), 1);
        check("snoop_set",   32'(l2i_snoop_set), 32'(set));
        check("lru_fill_en", 32'(l2i_dcache_lru_fill_en), 32'(op == OP_FILL));
        if (op == OP_FILL) check("lru_fill_set", 32'(l2i_dcache_lru_fill_set), 32'(set));
        issue(op, tag, set);
        last_op = op; last_set = set; last_cyc = cyc;
        done = 1'b1;
      end else begin
        check("stall_snoop_en", 32'(l2i_snoop_en), 0);
        check("stall_lru_en",   32'(l2i_dcache_lru_fill_en), 0);
        stalls++;
        if (stalls > 4) begin
          check("accept_timeout", 32'(stalls), 32'(exp_stall));
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (!done) @(negedge clk);
    end
    resp_valid = 1'b0;
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [TAG_W-1:0] tag_pool [4];
  logic [SET_W-1:0] set_pool [4];

  initial begin
    int c0;
    logic [SET_W-1:0] s;
    reset = 1'b1; resp_valid = 1'b0; resp_op = '0; resp_line_adr = '0;
    tag_pool[0] = 20'h01234; tag_pool[1] = 20'hABCDE; tag_pool[2] = 20'h00001; tag_pool[3] = 20'hFFFFF;
    set_pool[0] = 6'd5; set_pool[1] = 6'd7; set_pool[2] = 6'd9; set_pool[3] = 6'd63;
    ref_reset();
    idle(3);
    reset = 1'b0;

    // FILL miss into empty set 5 (victim way 2), then FILL hit on the same line.
    send(OP_FILL, 20'h01234, 6'd5);
    idle(1);
    send(OP_FILL, 20'h01234, 6'd5);
    // INVAL hit then INVAL miss on set 9.
    send(OP_FILL,  20'h0BEEF, 6'd9);
    send(OP_INVAL, 20'h0BEEF, 6'd9);
    send(OP_INVAL, 20'h0BEEF, 6'd9);
    // UPDATE hit then miss on set 63.
    send(OP_FILL,   20'h00077, 6'd63);
    send(OP_UPDATE, 20'h00077, 6'd63);
    send(OP_UPDATE, 20'h00078, 6'd63);
    send(2'd3,      20'h00077, 6'd63);
    // Back-to-back FILLs to set 7 take a one-cycle bubble; FILL then INVAL does not.
    idle(2);
    send(OP_FILL, 20'h00AAA, 6'd7);
    c0 = last_cyc;
    send(OP_FILL, 20'h00BBB, 6'd7);
    check("fill_fill_spacing", 32'(last_cyc - c0), 2);
    c0 = last_cyc;
    send(OP_INVAL, 20'h00AAA, 6'd7);
    check("fill_inval_spacing", 32'(last_cyc - c0), 1);

    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 4) == 0) ? SET_W'($urandom) : set_pool[$urandom_range(0, 3)];
      send(2'($urandom_range(0, 3)), tag_pool[$urandom_range(0, 3)], s);
      if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 2));
    end

    // Reset while stage 1 holds a FILL; a FILL is offered during reset.
    idle(2);
    send(OP_FILL, 20'h05555, 6'd20);
    reset = 1'b1;
    resp_valid = 1'b1; resp_op = OP_FILL; resp_line_adr = {20'h06666, 6'd20};
    idle(2);
    reset = 1'b0;
    ref_reset();
    send(OP_FILL, 20'h06666, 6'd20);
    send(OP_UPDATE, 20'h05555, 6'd20);

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
